// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches, pairs responses with their PCs
// and presents them in order through a small instruction buffer.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rstN,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pcOut,
    output logic [31:0] instructionOut,
    output logic        validOut
);

    localparam logic [0:0]  FETCH = 1'b0;
    localparam logic [0:0]  DRAIN = 1'b1;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [1:0]  LAST  = 2'(DEPTH - 1);
    localparam logic [3:0]  LIMIT = 4'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ibuf_ent_t;

    logic [0:0]  state;
    logic [31:0] fpc;
    logic [2:0]  outst;
    logic [2:0]  outst_nxt;
    logic [2:0]  bcnt;
    logic [2:0]  bcnt_nxt;
    logic [1:0]  pq_wr;
    logic [1:0]  pq_rd;
    logic [1:0]  bf_hd;
    logic [1:0]  bf_tl;
    logic [31:0] pq_mem [4];
    ibuf_ent_t   ibuf   [4];

    logic [3:0]  inflight;
    logic        fire;
    logic        rsp;
    logic        push;
    logic        pop;
    logic        unused_bits;

    // Ring-pointer advance, wrapping at the configured depth.
    function automatic logic [1:0] inc_ptr(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    assign unused_bits = ^redirect_pc[1:0];

    // Every issued request must have a buffer slot reserved for its reply.
    assign inflight  = {1'b0, outst} + {1'b0, bcnt};
    assign imem_req  = rstN && (state == FETCH)
                       && (inflight < LIMIT) && !redirect;
    assign imem_addr = fpc;
    assign fire      = imem_req && imem_gnt;

    // A reply with nothing outstanding is a protocol error and is ignored.
    assign rsp  = imem_rvalid && (outst != 3'd0);
    assign push = rsp && (state == FETCH) && !redirect;
    assign pop  = validOut && !stall && !redirect;

    assign validOut       = (bcnt != 3'd0);
    assign pcOut          = validOut ? ibuf[bf_hd].pc : 32'h0;
    assign instructionOut = validOut ? ibuf[bf_hd].instr : NOP;

    // Next occupancy of the in-flight request count.
    always_comb begin
        outst_nxt = outst;
        if (fire) outst_nxt = outst_nxt + 3'd1;
        if (rsp)  outst_nxt = outst_nxt - 3'd1;
    end

    // Next occupancy of the instruction buffer; redirect flushes it.
    always_comb begin
        bcnt_nxt = bcnt;
        if (redirect) begin
            bcnt_nxt = 3'd0;
        end else begin
            if (push) bcnt_nxt = bcnt_nxt + 3'd1;
            if (pop)  bcnt_nxt = bcnt_nxt - 3'd1;
        end
    end

    // Control state: fetch PC, counters, ring pointers and FETCH/DRAIN.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= FETCH;
            fpc   <= RESET_PC;
            outst <= 3'd0;
            bcnt  <= 3'd0;
            pq_wr <= 2'd0;
            pq_rd <= 2'd0;
            bf_hd <= 2'd0;
            bf_tl <= 2'd0;
        end else begin
            outst <= outst_nxt;
            bcnt  <= bcnt_nxt;
            if (fire) pq_wr <= inc_ptr(pq_wr);
            if (rsp)  pq_rd <= inc_ptr(pq_rd);
            if (redirect) begin
                fpc   <= {redirect_pc[31:2], 2'b00};
                bf_tl <= bf_hd;
                state <= (outst_nxt != 3'd0) ? DRAIN : FETCH;
            end else begin
                if (fire) fpc <= fpc + 32'd4;
                if (push) bf_tl <= inc_ptr(bf_tl);
                if (pop)  bf_hd <= inc_ptr(bf_hd);
                if (state == DRAIN && outst_nxt == 3'd0) state <= FETCH;
            end
        end
    end

    // Storage for queued PCs and buffered instruction pairs.
    always_ff @(posedge clk) begin
        if (fire) pq_mem[pq_wr] <= fpc;
        if (push) ibuf[bf_tl] <= '{pc: pq_mem[pq_rd], instr: imem_rdata};
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit with directed corner scenarios
// and a transaction-level model of the fetch stream.
module tb_fetch_unit;

    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pcOut;
    logic [31:0] instructionOut;
    logic        validOut;

    int n_tests = 0;
    int n_fail  = 0;
    int n_grants = 0;
    int gnt_pct = 100;
    int rv_pct  = 100;
    bit stray   = 1'b0;

    logic [31:0] mem_q [$];
    ent_t        exp_q [$];

    fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstN(rstN),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .pcOut(pcOut), .instructionOut(instructionOut),
        .validOut(validOut)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event at %0t", nm, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Memory: answers every granted address in order after random delay.
    initial begin
        forever begin
            @(negedge clk);
            if (rstN && imem_req && imem_gnt) mem_q.push_back(imem_addr);
            @(posedge clk);
            #1;
            if (!rstN) begin
                mem_q.delete();
                imem_rvalid = 1'b0;
            end else if (stray) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
            end else if (mem_q.size() > 0 && $urandom_range(99) < rv_pct) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_fn(mem_q.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
            imem_gnt = ($urandom_range(99) < gnt_pct);
        end
    end

    // Monitor: transaction model of the fetch stream plus scoreboard.
    initial begin
        logic [31:0] mfpc;
        int          m_outst;
        bit          m_drain;
        bit          prev_hold;
        bit          prev_redir;
        logic [31:0] prev_pc;
        logic [31:0] prev_ins;
        bit          grant;
        bit          rv_eff;
        ent_t        e;
        mfpc = RPC; m_outst = 0; m_drain = 0;
        prev_hold = 0; prev_redir = 0; prev_pc = 0; prev_ins = 0;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                chk("rst_req", {31'b0, imem_req}, 32'h0);
                chk("rst_valid", {31'b0, validOut}, 32'h0);
                chk("rst_pc", pcOut, 32'h0);
                chk("rst_ins", instructionOut, NOP);
                exp_q.delete();
                mfpc = RPC; m_outst = 0; m_drain = 0;
                prev_hold = 0; prev_redir = 0;
                continue;
            end
            grant  = imem_req && imem_gnt;
            rv_eff = imem_rvalid && (m_outst > 0);
            if (imem_req) chk("addr", imem_addr, mfpc);
            if (m_drain || redirect) chk("req_blocked", {31'b0, imem_req}, 32'h0);
            if (prev_redir) chk("post_redir_valid", {31'b0, validOut}, 32'h0);
            if (prev_hold) begin
                chk("hold_valid", {31'b0, validOut}, 32'h1);
                chk("hold_pc", pcOut, prev_pc);
                chk("hold_ins", instructionOut, prev_ins);
            end
            if (validOut) begin
                if (!stall && !redirect) begin
                    if (exp_q.size() == 0) begin
                        fail("unexpected_delivery");
                    end else begin
                        e = exp_q.pop_front();
                        chk("deliver_pc", pcOut, e.pc);
                        chk("deliver_ins", instructionOut, e.ins);
                    end
                end
            end else begin
                chk("idle_pc", pcOut, 32'h0);
                chk("idle_ins", instructionOut, NOP);
            end
            prev_hold  = validOut && stall && !redirect;
            prev_pc    = pcOut;
            prev_ins   = instructionOut;
            prev_redir = redirect;
            if (grant) n_grants++;
            if (redirect) begin
                exp_q.delete();
                if (rv_eff) m_outst--;
                m_drain = (m_outst > 0);
                mfpc    = {redirect_pc[31:2], 2'b00};
            end else begin
                if (grant) begin
                    exp_q.push_back('{pc: mfpc, ins: mem_fn(mfpc)});
                    mfpc = mfpc + 32'd4;
                    m_outst++;
                end
                if (rv_eff) begin
                    m_outst--;
                    if (m_drain && m_outst == 0) m_drain = 0;
                end
            end
        end
    end

    // Stimulus: directed corner cases, then a randomised soak.
    initial begin
        bit found;
        int g0;
        gnt_pct = 100;
        rv_pct  = 100;
        repeat (3) step();
        chk("reset_req", {31'b0, imem_req}, 32'h0);
        chk("reset_valid", {31'b0, validOut}, 32'h0);
        rstN = 1'b1;

        // Back-to-back stream: first output two cycles after first grant.
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) begin
                found = 1;
                break;
            end
        end
        if (!found) fail("first_grant");
        chk("first_addr", imem_addr, RPC);
        @(negedge clk);
        chk("lat_valid_early", {31'b0, validOut}, 32'h0);
        @(negedge clk);
        chk("lat_valid", {31'b0, validOut}, 32'h1);
        chk("lat_pc", pcOut, RPC);
        chk("lat_ins", instructionOut, mem_fn(RPC));
        repeat (20) step();

        // Long stall: bounded grants, requests stop, outputs frozen.
        stall = 1'b1;
        g0 = n_grants;
        repeat (10) step();
        chk("stall_req_low", {31'b0, imem_req}, 32'h0);
        chk("stall_grants_le_depth",
            {31'b0, (n_grants - g0) <= DEPTH}, 32'h1);
        stall = 1'b0;
        repeat (20) step();

        // Redirect with two requests outstanding; both replies dropped.
        rv_pct = 0;
        repeat (6) step();
        chk("two_outst_req_low", {31'b0, imem_req}, 32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0102;
        rv_pct = 100;
        step();
        redirect = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (validOut) begin
                found = 1;
                break;
            end
        end
        if (!found) fail("redir_first_valid");
        chk("redir_pc", pcOut, 32'h0000_0100);
        repeat (10) step();

        // Fetch address wraps past the top of the address space.
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) begin
                found = 1;
                break;
            end
        end
        if (!found) fail("wrap_grant");
        chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req) begin
                found = 1;
                break;
            end
        end
        if (!found) fail("wrap_next_req");
        chk("wrap_zero", imem_addr, 32'h0000_0000);
        repeat (10) step();

        // Stray response with nothing outstanding is ignored.
        gnt_pct = 0;
        repeat (10) step();
        stray = 1'b1;
        step();
        stray = 1'b0;
        repeat (3) step();
        chk("stray_ignored", {31'b0, validOut}, 32'h0);

        // Redirect, stall and a response all in the same cycle.
        stall = 1'b1;
        gnt_pct = 100;
        step();
        step();
        step();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect = 1'b0;
        stall = 1'b0;
        chk("combo_empty", {31'b0, validOut}, 32'h0);
        repeat (10) step();

        // Asynchronous reset mid-operation.
        rv_pct = 0;
        repeat (4) step();
        rstN = 1'b0;
        #1;
        chk("async_req", {31'b0, imem_req}, 32'h0);
        chk("async_valid", {31'b0, validOut}, 32'h0);
        chk("async_pc", pcOut, 32'h0);
        chk("async_ins", instructionOut, NOP);
        repeat (2) step();
        rv_pct = 100;
        rstN = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) begin
                found = 1;
                break;
            end
        end
        if (!found) fail("post_reset_grant");
        chk("post_reset_addr", imem_addr, RPC);

        // Randomised soak.
        for (int c = 0; c < 1500; c++) begin
            if (c % 50 == 0) begin
                gnt_pct = 30 + int'($urandom_range(70));
                rv_pct  = 30 + int'($urandom_range(70));
            end
            stall    = ($urandom_range(3) == 0);
            redirect = ($urandom_range(24) == 0);
            redirect_pc = ($urandom_range(3) == 0)
                        ? 32'hFFFF_FFF0 + 32'($urandom_range(15))
                        : $urandom;
            step();
        end
        stall = 1'b0;
        redirect = 1'b0;
        gnt_pct = 0;
        rv_pct = 100;
        repeat (30) step();
        chk("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
